// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM:
// states, opcode/funct values, ALU operation codes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    RESET, FETCH, DECODE, MEMADR, MEMRD, WB_LW, MEMWR,
    EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP, JR
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic       SRCA_PC   = 1'b0;
  localparam logic       SRCA_REG  = 1'b1;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_ALUOUT = 2'b10;

  localparam logic [1:0] WD_ALUOUT = 2'b00;
  localparam logic [1:0] WD_MDR    = 2'b01;
  localparam logic [1:0] WD_PC     = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational funct -> ALU operation map for R-type arithmetic.
// Unsupported funct codes fall back to add and are flagged as not valid.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       valid
);

  always_comb begin
    alu_op = ALU_ADD;
    valid  = 1'b1;
    unique case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle MIPS datapath: one state per clock,
// Moore-style strobes decoded from the state register.
module multicycle_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] cbit,
  input  logic [5:0] alucbit,
  output logic       PCwritecnt,
  output logic       PCwritecondbeq,
  output logic       PCwritecondbne,
  output logic       memread,
  output logic       memwrite,
  output logic       IorD,
  output logic       IRwrite,
  output logic       regWrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [2:0] aluOp,
  output logic [1:0] pcSrc,
  output logic [1:0] memtoreg,
  output logic [1:0] regDst
);

  state_t  state, state_next;
  alu_op_t funct_op;
  logic    funct_valid;

  mc_alu_decoder u_alu_decoder (
    .funct  (alucbit),
    .alu_op (funct_op),
    .valid  (funct_valid)
  );

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RESET;
    else     state <= state_next;
  end

  // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_next = FETCH;
    unique case (state)
      RESET:  state_next = FETCH;
      FETCH:  state_next = DECODE;
      DECODE: begin
        unique case (cbit)
          OP_LW, OP_SW:     state_next = MEMADR;
          OP_RTYPE: begin
            if (alucbit == FN_JR)  state_next = JR;
            else if (funct_valid)  state_next = EXEC_R;
            else                   state_next = FETCH;
          end
          OP_BEQ, OP_BNE:   state_next = BRANCH;
          OP_J, OP_JAL:     state_next = JUMP;
          OP_ADDI, OP_SLTI: state_next = EXEC_I;
          default:          state_next = FETCH;
        endcase
      end
      MEMADR: state_next = (cbit == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_next = WB_LW;
      EXEC_R: state_next = WB_R;
      EXEC_I: state_next = WB_I;
      default: state_next = FETCH;
    endcase
  end

  // Async reset drives state to RESET at once, so every strobe drops combinationally.
  always_comb begin
    PCwritecnt     = 1'b0;
    PCwritecondbeq = 1'b0;
    PCwritecondbne = 1'b0;
    memread        = 1'b0;
    memwrite       = 1'b0;
    IorD           = 1'b0;
    IRwrite        = 1'b0;
    regWrite       = 1'b0;
    alusrcA        = SRCA_PC;
    alusrcB        = SRCB_REG;
    aluOp          = ALU_ADD;
    pcSrc          = PC_ALU;
    memtoreg       = WD_ALUOUT;
    regDst         = DST_RT;
    unique case (state)
      FETCH: begin
        memread    = 1'b1;
        IRwrite    = 1'b1;
        alusrcB    = SRCB_FOUR;
        PCwritecnt = 1'b1;
      end
      DECODE: alusrcB = SRCB_IMM2;
      MEMADR: begin
        alusrcA = SRCA_REG;
        alusrcB = SRCB_IMM;
      end
      MEMRD: begin
        memread = 1'b1;
        IorD    = 1'b1;
      end
      WB_LW: begin
        regWrite = 1'b1;
        memtoreg = WD_MDR;
      end
      MEMWR: begin
        memwrite = 1'b1;
        IorD     = 1'b1;
      end
      EXEC_R: begin
        alusrcA = SRCA_REG;
        aluOp   = funct_op;
      end
      WB_R: begin
        regWrite = 1'b1;
        regDst   = DST_RD;
      end
      EXEC_I: begin
        alusrcA = SRCA_REG;
        alusrcB = SRCB_IMM;
        aluOp   = (cbit == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      WB_I: regWrite = 1'b1;
      BRANCH: begin
        alusrcA        = SRCA_REG;
        aluOp          = ALU_SUB;
        pcSrc          = PC_ALUOUT;
        PCwritecondbeq = (cbit == OP_BEQ);
        PCwritecondbne = (cbit == OP_BNE);
      end
      JUMP: begin
        pcSrc      = PC_JUMP;
        PCwritecnt = 1'b1;
        if (cbit == OP_JAL) begin
          regWrite = 1'b1;
          regDst   = DST_RA;
          memtoreg = WD_PC;
        end
      end
      JR: begin
        alusrcA    = SRCA_REG;
        PCwritecnt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction tables of expected
// per-cycle control words, plus hand-written reset sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cbit, alucbit;
  logic       PCwritecnt, PCwritecondbeq, PCwritecondbne, memread, memwrite;
  logic       IorD, IRwrite, regWrite, alusrcA;
  logic [1:0] alusrcB, pcSrc, memtoreg, regDst;
  logic [2:0] aluOp;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .cbit(cbit), .alucbit(alucbit),
    .PCwritecnt(PCwritecnt), .PCwritecondbeq(PCwritecondbeq),
    .PCwritecondbne(PCwritecondbne), .memread(memread), .memwrite(memwrite),
    .IorD(IorD), .IRwrite(IRwrite), .regWrite(regWrite), .alusrcA(alusrcA),
    .alusrcB(alusrcB), .aluOp(aluOp), .pcSrc(pcSrc), .memtoreg(memtoreg),
    .regDst(regDst)
  );

  always #5 clk = ~clk;

  // strobes = {PCwritecnt, beq, bne, memread, memwrite, IorD, IRwrite, regWrite, alusrcA}
  typedef struct packed {
    logic [8:0] strobes;
    logic [1:0] asb;
    logic [2:0] op;
    logic [1:0] pcs;
    logic [1:0] m2r;
    logic [1:0] rd;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    int         len;
    ctl_t [0:4] exp;
  } vec_t;

  localparam ctl_t E_ZERO   = '0;
  localparam ctl_t E_FETCH  = {9'b100100100, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_DECODE = {9'b000000000, 2'b11, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_MEMADR = {9'b000000001, 2'b10, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_MEMRD  = {9'b000101000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_WBLW   = {9'b000000010, 2'b00, 3'b000, 2'b00, 2'b01, 2'b00};
  localparam ctl_t E_MEMWR  = {9'b000011000, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_WBR    = {9'b000000010, 2'b00, 3'b000, 2'b00, 2'b00, 2'b01};
  localparam ctl_t E_WBI    = {9'b000000010, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};
  localparam ctl_t E_BEQ    = {9'b010000001, 2'b00, 3'b001, 2'b10, 2'b00, 2'b00};
  localparam ctl_t E_BNE    = {9'b001000001, 2'b00, 3'b001, 2'b10, 2'b00, 2'b00};
  localparam ctl_t E_J      = {9'b100000000, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00};
  localparam ctl_t E_JAL    = {9'b100000010, 2'b00, 3'b000, 2'b01, 2'b10, 2'b10};
  localparam ctl_t E_JR     = {9'b100000001, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00};

  function automatic ctl_t exec_r(input logic [2:0] op);
    return {9'b000000001, 2'b00, op, 2'b00, 2'b00, 2'b00};
  endfunction

  function automatic ctl_t exec_i(input logic [2:0] op);
    return {9'b000000001, 2'b10, op, 2'b00, 2'b00, 2'b00};
  endfunction

  function automatic ctl_t sample();
    return {PCwritecnt, PCwritecondbeq, PCwritecondbne, memread, memwrite, IorD,
            IRwrite, regWrite, alusrcA, alusrcB, aluOp, pcSrc, memtoreg, regDst};
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input ctl_t act, input ctl_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[16];
  int   nv = 0;

  task automatic add_vec(input string name, input logic [5:0] op, input logic [5:0] fn,
                         input int len, input ctl_t e0, input ctl_t e1, input ctl_t e2,
                         input ctl_t e3, input ctl_t e4);
    vecs[nv].name = name;
    vecs[nv].op   = op;
    vecs[nv].fn   = fn;
    vecs[nv].len  = len;
    vecs[nv].exp  = {e0, e1, e2, e3, e4};
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    add_vec("lw",      6'h23, 6'h00, 5, E_FETCH, E_DECODE, E_MEMADR, E_MEMRD, E_WBLW);
    add_vec("sw",      6'h2B, 6'h00, 4, E_FETCH, E_DECODE, E_MEMADR, E_MEMWR, E_ZERO);
    add_vec("add",     6'h00, 6'h20, 4, E_FETCH, E_DECODE, exec_r(3'b000), E_WBR, E_ZERO);
    add_vec("sub",     6'h00, 6'h22, 4, E_FETCH, E_DECODE, exec_r(3'b001), E_WBR, E_ZERO);
    add_vec("and",     6'h00, 6'h24, 4, E_FETCH, E_DECODE, exec_r(3'b010), E_WBR, E_ZERO);
    add_vec("or",      6'h00, 6'h25, 4, E_FETCH, E_DECODE, exec_r(3'b011), E_WBR, E_ZERO);
    add_vec("slt",     6'h00, 6'h2A, 4, E_FETCH, E_DECODE, exec_r(3'b100), E_WBR, E_ZERO);
    add_vec("addi",    6'h08, 6'h2A, 4, E_FETCH, E_DECODE, exec_i(3'b000), E_WBI, E_ZERO);
    add_vec("slti",    6'h0A, 6'h00, 4, E_FETCH, E_DECODE, exec_i(3'b100), E_WBI, E_ZERO);
    add_vec("beq",     6'h04, 6'h00, 3, E_FETCH, E_DECODE, E_BEQ, E_ZERO, E_ZERO);
    add_vec("bne",     6'h05, 6'h00, 3, E_FETCH, E_DECODE, E_BNE, E_ZERO, E_ZERO);
    add_vec("j",       6'h02, 6'h00, 3, E_FETCH, E_DECODE, E_J, E_ZERO, E_ZERO);
    add_vec("jal",     6'h03, 6'h00, 3, E_FETCH, E_DECODE, E_JAL, E_ZERO, E_ZERO);
    add_vec("jr",      6'h00, 6'h08, 3, E_FETCH, E_DECODE, E_JR, E_ZERO, E_ZERO);
    add_vec("illegal", 6'h3F, 6'h00, 2, E_FETCH, E_DECODE, E_ZERO, E_ZERO, E_ZERO);
    add_vec("badfunct",6'h00, 6'h01, 2, E_FETCH, E_DECODE, E_ZERO, E_ZERO, E_ZERO);

    // Reset held for three cycles, released between edges.
    rst = 1'b1; cbit = 6'h00; alucbit = 6'h00;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_cycle%0d", i), sample(), E_ZERO);
      step();
    end
    rst = 1'b0;
    check("reset_released", sample(), E_ZERO);
    step();
    check("first_fetch", sample(), E_FETCH);

    // Table: each entry starts at FETCH and must return to FETCH after len cycles.
    for (int v = 0; v < nv; v++) begin
      cbit    = vecs[v].op;
      alucbit = vecs[v].fn;
      for (int c = 0; c < vecs[v].len; c++) begin
        check($sformatf("%s_cycle%0d", vecs[v].name, c), sample(), vecs[v].exp[c]);
        step();
      end
      check($sformatf("%s_back_to_fetch", vecs[v].name), sample(), E_FETCH);
    end

    // rst pulsed in MEMWR: memwrite must drop without waiting for a clock edge.
    cbit = 6'h2B; alucbit = 6'h00;
    step(); step(); step();
    check("sw_in_memwr", sample(), E_MEMWR);
    #1 rst = 1'b1;
    #1 check("rst_async_clear", sample(), E_ZERO);
    @(negedge clk);
    check("rst_held", sample(), E_ZERO);
    rst = 1'b0;
    step();
    check("restart_fetch", sample(), E_FETCH);
    step();
    check("restart_decode", sample(), E_DECODE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
